// File: rtl/rd_sched_phase2.sv
// Phase-2 read scheduler: splits 16 equal-sized per-stream reads into
// 4 KB-safe requests, granted round-robin among streams holding a credit.
// Optional stall counter enabled with macro RD_SCHED_PHASE2_PERF_EN.
module rd_sched_phase2 #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_BURST_BYTES      = 4096
) (
  input  logic                                 aclk,
  input  logic                                 areset_n,
  input  logic                                 i_start,
  input  logic [15:0][C_M_AXI_ADDR_WIDTH-1:0]  i_read_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]         i_read_size_in_bytes,
  input  logic [15:0]                          i_credit,
  output logic                                 o_req_valid,
  input  logic                                 i_req_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        o_req_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]         o_req_size,
  output logic [3:0]                           o_req_id,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [31:0]                          o_stall_cycles
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_XFER_SIZE_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARB, S_ISSUE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      ptr;
  logic [AW-1:0]   addr_q [16];
  logic [SW-1:0]   rem_q  [16];
  logic [SW-1:0]   size_trunc;
  logic [15:0]     elig;
  logic            pick_found;
  logic [3:0]      pick_id;
  logic [SW-1:0]   pick_size;
  logic            hs;
  logic            last_req;

  // Request length: remaining bytes, clipped to the burst limit and to the
  // distance to the next 4 KB boundary.
  function automatic logic [SW-1:0] req_len(input logic [SW-1:0] rem,
                                            input logic [11:0]   off);
    logic [SW-1:0] len;
    logic [SW-1:0] bnd;
    bnd = SW'(13'd4096 - {1'b0, off});
    len = rem;
    if (len > SW'(C_BURST_BYTES)) len = SW'(C_BURST_BYTES);
    if (len > bnd) len = bnd;
    return len;
  endfunction

  assign size_trunc = i_read_size_in_bytes & ~SW'(63);
  assign hs         = (state == S_ISSUE) && o_req_valid && i_req_ready;

  // Eligibility and round-robin pick starting at the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr;
    for (int s = 0; s < 16; s++) begin
      elig[s] = (rem_q[s] != '0) && i_credit[s];
    end
    for (int i = 0; i < 16; i++) begin
      if (!pick_found && elig[ptr + 4'(i)]) begin
        pick_found = 1'b1;
        pick_id    = ptr + 4'(i);
      end
    end
    pick_size = req_len(rem_q[pick_id], addr_q[pick_id][11:0]);
  end

  // The granted request drains the last outstanding bytes of the job.
  always_comb begin
    last_req = 1'b1;
    for (int s = 0; s < 16; s++) begin
      if (4'(s) == o_req_id) begin
        if (rem_q[s] != o_req_size) last_req = 1'b0;
      end else if (rem_q[s] != '0) begin
        last_req = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (size_trunc == '0) ? S_DONE : S_ARB;
      S_ARB:   if (pick_found) state_nxt = S_ISSUE;
      S_ISSUE: if (hs) state_nxt = last_req ? S_DONE : S_ARB;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Request outputs, pointer and status flags.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ptr         <= '0;
      o_req_valid <= 1'b0;
      o_req_addr  <= '0;
      o_req_size  <= '0;
      o_req_id    <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_busy <= (state != S_IDLE);
      o_done <= (state == S_DONE);
      if (state == S_ARB && pick_found) begin
        o_req_valid <= 1'b1;
        o_req_addr  <= addr_q[pick_id];
        o_req_size  <= pick_size;
        o_req_id    <= pick_id;
      end else if (hs) begin
        o_req_valid <= 1'b0;
        ptr         <= o_req_id + 4'd1;
      end
    end
  end

  // Per-stream remaining-byte counters.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int s = 0; s < 16; s++) rem_q[s] <= '0;
    end else if (state == S_LOAD) begin
      for (int s = 0; s < 16; s++) rem_q[s] <= size_trunc;
    end else if (hs) begin
      rem_q[o_req_id] <= rem_q[o_req_id] - o_req_size;
    end
  end

  // Per-stream address registers (data path, no reset needed).
  always_ff @(posedge aclk) begin
    if (state == S_LOAD) begin
      for (int s = 0; s < 16; s++) addr_q[s] <= i_read_addr[s];
    end else if (hs) begin
      addr_q[o_req_id] <= addr_q[o_req_id] + AW'(o_req_size);
    end
  end

`ifdef RD_SCHED_PHASE2_PERF_EN
  logic work_left;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    work_left = 1'b0;
    for (int s = 0; s < 16; s++) if (rem_q[s] != '0) work_left = 1'b1;
  end

  // Count arbitration cycles where work is pending but no stream has credit.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                                   o_stall_cycles <= '0;
    else if (state == S_LOAD)                        o_stall_cycles <= '0;
    else if (state == S_ARB && work_left && !pick_found)
                                                     o_stall_cycles <= sat_inc(o_stall_cycles);
  end
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rd_sched_phase2.sv
// Scoreboard bench for rd_sched_phase2: scenarios push expected requests,
// a negedge monitor pops and compares on every handshake.
module tb_rd_sched_phase2;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] size;
  } req_t;

  logic             aclk = 1'b0;
  logic             areset_n = 1'b0;
  logic             i_start = 1'b0;
  logic [15:0][63:0] rd_addr;
  logic [63:0]      rd_size = '0;
  logic [15:0]      credit = '0;
  logic             o_req_valid;
  logic             i_req_ready = 1'b0;
  logic [63:0]      o_req_addr;
  logic [63:0]      o_req_size;
  logic [3:0]       o_req_id;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_stall_cycles;

  req_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     hs_cyc = 0;
  bit     hs_seen = 1'b0;

  rd_sched_phase2 dut (
    .aclk                 (aclk),
    .areset_n             (areset_n),
    .i_start              (i_start),
    .i_read_addr          (rd_addr),
    .i_read_size_in_bytes (rd_size),
    .i_credit             (credit),
    .o_req_valid          (o_req_valid),
    .i_req_ready          (i_req_ready),
    .o_req_addr           (o_req_addr),
    .o_req_size           (o_req_size),
    .o_req_id             (o_req_id),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_stall_cycles       (o_stall_cycles)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] base(input int s);
    return 64'h1_0000_0000 + 64'(s) * 64'h1_0000;
  endfunction

  task automatic push(input int id, input logic [63:0] addr, input logic [63:0] size);
    req_t r;
    r.id = 4'(id); r.addr = addr; r.size = size;
    exp_q.push_back(r);
  endtask

  // Monitor: compare each handshake against the scoreboard, and check the
  // o_done pulse lands two cycles after the final handshake.
  always @(negedge aclk) begin
    req_t r;
    cyc++;
    if (areset_n && o_req_valid && i_req_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: got id %0d addr 0x%0h size %0d, none expected",
                 o_req_id, o_req_addr, o_req_size);
      end else begin
        r = exp_q.pop_front();
        chk("req_id",   64'(o_req_id), 64'(r.id));
        chk("req_addr", o_req_addr, r.addr);
        chk("req_size", o_req_size, r.size);
      end
      hs_cyc  = cyc;
      hs_seen = 1'b1;
    end
    if (areset_n && o_done && hs_seen) begin
      chk("done_latency", 64'(cyc - hs_cyc), 64'd2);
      hs_seen = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1;
    areset_n = 1'b0;
    i_start = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
    hs_seen = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1 i_start = 1'b1;
    @(posedge aclk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (o_done) begin seen = 1'b1; break; end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_busy_at_done"}, 64'(o_busy), 64'd1);
    @(negedge aclk);
    chk({nm, "_done_one_cycle"}, 64'(o_done), 64'd0);
    chk({nm, "_busy_after"}, 64'(o_busy), 64'd0);
    chk({nm, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (o_req_valid) begin seen = 1'b1; break; end
    end
    chk({nm, "_valid_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    bit seen;
    for (int s = 0; s < 16; s++) rd_addr[s] = base(s);

    // Reset state
    #2;
    chk("rst_valid", 64'(o_req_valid), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_done",  64'(o_done), 64'd0);
    chk("rst_addr",  o_req_addr, 64'd0);
    chk("rst_size",  o_req_size, 64'd0);
    chk("rst_id",    64'(o_req_id), 64'd0);
    chk("rst_stall", 64'(o_stall_cycles), 64'd0);
    do_reset();

    // 512 B per stream: one request each, ids 0..15
    rd_size = 64'd512; credit = 16'hFFFF; i_req_ready = 1'b1;
    for (int s = 0; s < 16; s++) push(s, base(s), 64'd512);
    pulse_start();
    wait_done("t512", 200);

    // 8192 B per stream: two 4 KB passes
    do_reset();
    rd_size = 64'd8192;
    for (int s = 0; s < 16; s++) push(s, base(s), 64'd4096);
    for (int s = 0; s < 16; s++) push(s, base(s) + 64'h1000, 64'd4096);
    pulse_start();
    wait_done("t8k", 400);

    // Stream 3 straddles a 4 KB boundary
    do_reset();
    rd_size = 64'd1024;
    rd_addr[3] = base(3) + 64'hF80;
    for (int s = 0; s < 16; s++) begin
      if (s == 3) push(3, base(3) + 64'hF80, 64'd128);
      else        push(s, base(s), 64'd1024);
    end
    push(3, base(3) + 64'h1000, 64'd896);
    pulse_start();
    wait_done("t4kb", 200);
    rd_addr[3] = base(3);

    // Credits on 5 and 9 only, ready held low, i_start during ISSUE ignored
    do_reset();
    rd_size = 64'd8192; credit = 16'h0220; i_req_ready = 1'b0;
    push(5, base(5), 64'd4096);
    push(9, base(9), 64'd4096);
    push(5, base(5) + 64'h1000, 64'd4096);
    push(9, base(9) + 64'h1000, 64'd4096);
    pulse_start();
    wait_valid("tcred", 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (i == 3) i_start = 1'b1;
      if (i == 4) i_start = 1'b0;
      chk("hold_valid", 64'(o_req_valid), 64'd1);
      chk("hold_id",    64'(o_req_id), 64'd5);
      chk("hold_addr",  o_req_addr, base(5));
      chk("hold_size",  o_req_size, 64'd4096);
    end
    @(posedge aclk); #1 i_req_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) begin seen = 1'b1; break; end
    end
    chk("tcred_first4_drained", 64'(seen), 64'd1);
    repeat (8) @(posedge aclk);
    #1;
`ifdef RD_SCHED_PHASE2_PERF_EN
    chk("stall_counting", 64'(o_stall_cycles != 0), 64'd1);
`else
    chk("stall_const0", 64'(o_stall_cycles), 64'd0);
`endif
    chk("stall_no_valid", 64'(o_req_valid), 64'd0);
    for (int k = 10; k < 26; k++)
      if ((k % 16) != 5 && (k % 16) != 9) push(k % 16, base(k % 16), 64'd4096);
    for (int k = 10; k < 26; k++)
      if ((k % 16) != 5 && (k % 16) != 9) push(k % 16, base(k % 16) + 64'h1000, 64'd4096);
    credit = 16'hFFFF;
    wait_done("tcred", 400);

    // Truncated size 0: straight to DONE, no requests
    do_reset();
    rd_size = 64'h3F;
    pulse_start();
    wait_done("tzero", 20);

    // Reset during ISSUE drops the request; new start replays from id 0
    do_reset();
    rd_size = 64'd512; i_req_ready = 1'b0;
    pulse_start();
    wait_valid("trst", 20);
    @(posedge aclk); #1 areset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_req_valid), 64'd0);
    chk("mid_rst_busy",  64'(o_busy), 64'd0);
    chk("mid_rst_addr",  o_req_addr, 64'd0);
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("post_rst_idle_valid", 64'(o_req_valid), 64'd0);
    chk("post_rst_idle_busy",  64'(o_busy), 64'd0);
    for (int s = 0; s < 16; s++) push(s, base(s), 64'd512);
    i_req_ready = 1'b1;
    pulse_start();
    wait_done("treplay", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
